// File: rtl/hazard_ctrl_bp.sv
// hazard_ctrl_bp: pipeline hazard/control-flow unit with a BHT branch predictor, an LDI/STI FSM,
// a post-redirect squash cycle and saturating perf counters. Optional feature macro: HAZ_DYNAMIC_BP_EN.
`default_nettype none

module hazard_ctrl_bp #(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int PC_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_mem_resp,
    input  logic                 d_mem_resp,
    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  logic                 mem_is_ind,
    input  logic                 id_is_br,
    input  logic [PC_WIDTH-1:0]  id_pc,
    input  logic                 id_is_jmp,
    input  logic                 ex_is_jmp,
    input  logic                 mem_is_jmp,
    input  logic                 wb_is_br,
    input  logic [PC_WIDTH-1:0]  wb_pc,
    input  logic                 wb_br_taken,
    input  logic                 wb_pred_taken,
    input  logic                 wb_is_jmp,
    input  logic                 perf_clear,
    output logic                 predict_taken,
    output logic                 load,
    output logic                 load_pc,
    output logic                 pc_redirect,
    output logic                 flush,
    output logic                 flush_mem_op,
    output logic                 i_mem_read,
    output logic [CNT_WIDTH-1:0] bpredicts,
    output logic [CNT_WIDTH-1:0] bmispredicts,
    output logic [CNT_WIDTH-1:0] stalls
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_IND_A  = 2'd1,
        S_IND_B  = 2'd2,
        S_SQUASH = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_mispredict;
    logic   w_mem_op;
    logic   w_pred;
    logic   w_unused;

    // Only the index bits of the PCs are consumed; the rest are deliberately ignored.
    assign w_unused = ^{id_pc, wb_pc, wb_pred_taken, id_is_br};
    assign w_mem_op = d_mem_read | d_mem_write;

`ifdef HAZ_DYNAMIC_BP_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [IDX_W-1:0] w_id_idx;
    logic [IDX_W-1:0] w_wb_idx;

    assign w_id_idx     = id_pc[IDX_W:1];
    assign w_wb_idx     = wb_pc[IDX_W:1];
    assign w_pred       = id_is_br & r_bht[w_id_idx][1];
    assign w_mispredict = wb_is_br & (wb_br_taken != wb_pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (wb_is_br && load) begin
            if (wb_br_taken && r_bht[w_wb_idx] != 2'b11)
                r_bht[w_wb_idx] <= r_bht[w_wb_idx] + 2'b01;
            else if (!wb_br_taken && r_bht[w_wb_idx] != 2'b00)
                r_bht[w_wb_idx] <= r_bht[w_wb_idx] - 2'b01;
        end
    end
`else
    assign w_pred       = 1'b0;
    assign w_mispredict = wb_is_br & wb_br_taken;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        load          = 1'b1;
        load_pc       = 1'b0;
        pc_redirect   = 1'b0;
        flush         = 1'b0;
        flush_mem_op  = 1'b0;
        i_mem_read    = 1'b1;
        predict_taken = w_pred;

        case (r_state)
            S_RUN: begin
                if (mem_is_ind && w_mem_op) begin
                    load   = 1'b0;
                    w_next = S_IND_A;
                end else if (w_mem_op && !d_mem_resp) begin
                    load = 1'b0;
                end
            end
            S_IND_A: begin
                load = 1'b0;
                if (d_mem_resp) w_next = S_IND_B;
            end
            S_IND_B: begin
                load = d_mem_resp;
                if (d_mem_resp) w_next = S_RUN;
            end
            default: begin
                load   = 1'b0;
                w_next = S_RUN;
            end
        endcase

        if (id_is_jmp || ex_is_jmp || mem_is_jmp || wb_is_jmp || w_mispredict || r_state == S_SQUASH)
            i_mem_read = 1'b0;
        load_pc = load & i_mem_resp & i_mem_read;

        // A WB mispredict overrides every stall and aborts any in-progress indirect access.
        if (w_mispredict) begin
            flush        = 1'b1;
            flush_mem_op = 1'b1;
            load         = 1'b1;
            load_pc      = 1'b1;
            pc_redirect  = 1'b1;
            w_next       = S_SQUASH;
        end else if (wb_is_jmp) begin
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
        end

        if (reset) begin
            load          = 1'b1;
            load_pc       = 1'b0;
            pc_redirect   = 1'b0;
            flush         = 1'b0;
            flush_mem_op  = 1'b0;
            i_mem_read    = 1'b1;
            predict_taken = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            bpredicts    <= '0;
            bmispredicts <= '0;
            stalls       <= '0;
        end else begin
            if (wb_is_br && load && !w_mispredict && !(&bpredicts))
                bpredicts <= bpredicts + 1'b1;
            if (w_mispredict && !(&bmispredicts))
                bmispredicts <= bmispredicts + 1'b1;
            if (!load && !(&stalls))
                stalls <= stalls + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_bp.sv
// tb_hazard_ctrl_bp: scoreboard bench for hazard_ctrl_bp with a rule-level reference model.
`default_nettype none

module tb_hazard_ctrl_bp;

    localparam int BHT = 16;
    localparam int CW  = 6;
    localparam int PW  = 16;
    localparam int CMAX = (1 << CW) - 1;

`ifdef HAZ_DYNAMIC_BP_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, i_mem_resp, d_mem_resp, d_mem_read, d_mem_write, mem_is_ind;
    logic id_is_br, id_is_jmp, ex_is_jmp, mem_is_jmp;
    logic wb_is_br, wb_br_taken, wb_pred_taken, wb_is_jmp, perf_clear;
    logic [PW-1:0] id_pc, wb_pc;
    logic predict_taken, load, load_pc, pc_redirect, flush, flush_mem_op, i_mem_read;
    logic [CW-1:0] bpredicts, bmispredicts, stalls;

    hazard_ctrl_bp #(.BHT_ENTRIES(BHT), .CNT_WIDTH(CW), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .i_mem_resp(i_mem_resp), .d_mem_resp(d_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .mem_is_ind(mem_is_ind),
        .id_is_br(id_is_br), .id_pc(id_pc), .id_is_jmp(id_is_jmp), .ex_is_jmp(ex_is_jmp),
        .mem_is_jmp(mem_is_jmp), .wb_is_br(wb_is_br), .wb_pc(wb_pc), .wb_br_taken(wb_br_taken),
        .wb_pred_taken(wb_pred_taken), .wb_is_jmp(wb_is_jmp), .perf_clear(perf_clear),
        .predict_taken(predict_taken), .load(load), .load_pc(load_pc), .pc_redirect(pc_redirect),
        .flush(flush), .flush_mem_op(flush_mem_op), .i_mem_read(i_mem_read),
        .bpredicts(bpredicts), .bmispredicts(bmispredicts), .stalls(stalls)
    );

    typedef struct {
        bit pt, ld, ldpc, redir, fl, flm, imr;
        int bp, bm, st;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: indirect-access phase (0 none, 1 awaiting pointer, 2 awaiting data),
    // a pending squash flag, the predictor table and the three counters.
    int m_phase;
    bit m_squash;
    int m_bht[BHT];
    int m_bp, m_bm, m_st;

    function automatic int idx(input logic [PW-1:0] pc);
        return (int'(pc) >> 1) % BHT;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_squash = 0; m_bp = 0; m_bm = 0; m_st = 0;
        for (int i = 0; i < BHT; i++) m_bht[i] = 1;
    endtask

    task automatic apply();
        exp_t e;
        bit mp, memop, fsm_ld;
        e.bp = m_bp; e.bm = m_bm; e.st = m_st;
        if (reset) begin
            e.pt = 0; e.ld = 1; e.ldpc = 0; e.redir = 0; e.fl = 0; e.flm = 0; e.imr = 1;
            q.push_back(e);
            model_reset();
            return;
        end
        mp    = wb_is_br && (DYN ? (wb_br_taken != wb_pred_taken) : wb_br_taken);
        memop = d_mem_read || d_mem_write;
        if (m_squash)          fsm_ld = 0;
        else if (m_phase == 1) fsm_ld = 0;
        else if (m_phase == 2) fsm_ld = d_mem_resp;
        else                   fsm_ld = !(memop && (mem_is_ind || !d_mem_resp));
        e.ld    = mp ? 1'b1 : fsm_ld;
        e.imr   = !(id_is_jmp || ex_is_jmp || mem_is_jmp || wb_is_jmp || mp || m_squash);
        e.ldpc  = mp || wb_is_jmp || (e.ld && i_mem_resp && e.imr);
        e.redir = mp || wb_is_jmp;
        e.fl    = mp;
        e.flm   = mp;
        e.pt    = DYN && id_is_br && (m_bht[idx(id_pc)] >= 2);
        q.push_back(e);

        if (DYN && wb_is_br && e.ld) begin
            if (wb_br_taken) m_bht[idx(wb_pc)] = (m_bht[idx(wb_pc)] < 3) ? m_bht[idx(wb_pc)] + 1 : 3;
            else             m_bht[idx(wb_pc)] = (m_bht[idx(wb_pc)] > 0) ? m_bht[idx(wb_pc)] - 1 : 0;
        end
        if (perf_clear) begin
            m_bp = 0; m_bm = 0; m_st = 0;
        end else begin
            if (wb_is_br && e.ld && !mp) m_bp = (m_bp < CMAX) ? m_bp + 1 : CMAX;
            if (mp)                      m_bm = (m_bm < CMAX) ? m_bm + 1 : CMAX;
            if (!e.ld)                   m_st = (m_st < CMAX) ? m_st + 1 : CMAX;
        end
        if (mp) begin
            m_squash = 1; m_phase = 0;
        end else if (m_squash) begin
            m_squash = 0;
        end else if (m_phase == 0) begin
            if (memop && mem_is_ind) m_phase = 1;
        end else if (m_phase == 1) begin
            if (d_mem_resp) m_phase = 2;
        end else if (d_mem_resp) begin
            m_phase = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("predict_taken", int'(predict_taken), int'(e.pt));
            chk("load",          int'(load),          int'(e.ld));
            chk("load_pc",       int'(load_pc),       int'(e.ldpc));
            chk("pc_redirect",   int'(pc_redirect),   int'(e.redir));
            chk("flush",         int'(flush),         int'(e.fl));
            chk("flush_mem_op",  int'(flush_mem_op),  int'(e.flm));
            chk("i_mem_read",    int'(i_mem_read),    int'(e.imr));
            chk("bpredicts",     int'(bpredicts),     e.bp);
            chk("bmispredicts",  int'(bmispredicts),  e.bm);
            chk("stalls",        int'(stalls),        e.st);
        end
    end

    task automatic idle();
        reset = 0; i_mem_resp = 1; d_mem_resp = 0; d_mem_read = 0; d_mem_write = 0;
        mem_is_ind = 0; id_is_br = 0; id_pc = '0; id_is_jmp = 0; ex_is_jmp = 0;
        mem_is_jmp = 0; wb_is_br = 0; wb_pc = '0; wb_br_taken = 0; wb_pred_taken = 0;
        wb_is_jmp = 0; perf_clear = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [PW-1:0] pick_pc();
        logic [PW-1:0] pcs [4];
        pcs[0] = 16'h0010; pcs[1] = 16'h0012; pcs[2] = 16'h0030; pcs[3] = 16'h0104;
        return pcs[$urandom_range(3)];
    endfunction

    initial begin
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1; apply();
        tick(); apply();                                       // idle after reset
        tick(); apply();

        for (int i = 0; i < 4; i++) begin                       // plain load stall
            tick(); d_mem_read = 1; d_mem_resp = (i == 3); apply();
        end
        for (int i = 0; i < 6; i++) begin                       // LDI double access
            tick(); d_mem_read = 1; mem_is_ind = 1; d_mem_resp = (i == 2 || i == 5); apply();
        end
        for (int i = 0; i < 2; i++) begin                       // branch at 0x0010 taken twice
            tick(); wb_is_br = 1; wb_pc = 16'h0010; wb_br_taken = 1; wb_pred_taken = 0; apply();
            tick(); apply();
        end
        tick(); id_is_br = 1; id_pc = 16'h0010; apply();
        tick(); wb_is_br = 1; wb_pc = 16'h0010; wb_br_taken = 1; wb_pred_taken = DYN; apply();
        tick(); d_mem_read = 1; mem_is_ind = 1; d_mem_resp = 1; apply();  // LDI aborted in IND_B
        tick(); d_mem_read = 1; mem_is_ind = 1; d_mem_resp = 1; apply();
        tick(); d_mem_read = 1; mem_is_ind = 1; wb_is_br = 1; wb_br_taken = 1; apply();
        tick(); apply();
        tick(); apply();
        for (int i = 0; i < 70; i++) begin                      // drive stalls into saturation
            tick(); d_mem_write = 1; apply();
        end
        tick(); d_mem_write = 1; perf_clear = 1; apply();       // clear beats increment
        tick(); apply();

        for (int i = 0; i < 4000; i++) begin
            tick();
            reset       = ($urandom_range(499) == 0);
            perf_clear  = ($urandom_range(59) == 0);
            i_mem_resp  = ($urandom_range(3) != 0);
            d_mem_resp  = $urandom_range(1);
            d_mem_read  = ($urandom_range(3) == 0);
            d_mem_write = ($urandom_range(7) == 0);
            mem_is_ind  = ($urandom_range(3) == 0);
            id_is_br    = $urandom_range(1);
            id_pc       = pick_pc();
            id_is_jmp   = ($urandom_range(19) == 0);
            ex_is_jmp   = ($urandom_range(19) == 0);
            mem_is_jmp  = ($urandom_range(19) == 0);
            wb_is_jmp   = ($urandom_range(19) == 0);
            wb_is_br    = ($urandom_range(3) == 0);
            wb_pc       = pick_pc();
            wb_br_taken = $urandom_range(1);
            wb_pred_taken = ($urandom_range(3) == 0) ? 1'($urandom_range(1))
                                                     : 1'(DYN && m_bht[idx(wb_pc)] >= 2);
            apply();
        end
        tick();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
